// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment display driver with a shadow value register,
// per-digit refresh scanning, anode dead-time, hex/decimal glyphs, leading-zero
// suppression, decimal points and a frame tick.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   enable       - 1 = scan display, 0 = all digits off
//   load         - capture value/dp_in/blank_lz into the shadow this cycle
//   value        - nibble i drives digit i (digit 0 least significant)
//   dp_in        - active-high decimal point per digit
//   blank_lz     - leading-zero suppression enable
//   ssd          - segments, active low, [7:1] = a..g, [0] = dp
//   an           - anode selects, active low
//   frame_tick   - one-cycle pulse on the first cycle of each wrapped scan
module ssd_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned HEX_MODE    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [7:0]                ssd,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_tick
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] RD_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           digit_q, digit_d, digit_next;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    blz_q, blz_d;
  logic                    frame_d;
  logic [7:0]              ssd_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [NUM_DIGITS-1:0]   lz_blank;

  // Active-low a..g pattern for one nibble; 10..15 blank unless hex glyphs enabled.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h30;
      default: g = 7'h38;
    endcase
    if (HEX_MODE == 0 && nib > 4'h9) g = 7'h7F;
    return g;
  endfunction

  // Next-state, next-shadow and frame-tick decode.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    cnt_d      = cnt_q;
    frame_d    = 1'b0;
    val_d      = load ? value    : val_q;
    dp_d       = load ? dp_in    : dp_q;
    blz_d      = load ? blank_lz : blz_q;
    digit_next = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = DRIVE;
          digit_d = '0;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == RD_LAST) begin
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else begin
            digit_d = digit_next;
            frame_d = (digit_q == DIGIT_LAST);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
          digit_d = digit_next;
          frame_d = (digit_q == DIGIT_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        digit_d = '0;
        cnt_d   = '0;
      end
    endcase

    if (!enable) begin
      state_d = IDLE;
      digit_d = '0;
      cnt_d   = '0;
      frame_d = 1'b0;
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and every higher nibble are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero && (val_d[4*i +: 4] == 4'h0);
      lz_blank[i] = blz_d && all_zero && (i > 0);
    end
  end

  // Output decode from the next state so registered outputs track the state register.
  always_comb begin
    ssd_d = 8'hFF;
    an_d  = '1;
    if (state_d == DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_d == DW'(i)) begin
          an_d[i]    = 1'b0;
          ssd_d[7:1] = lz_blank[i] ? 7'h7F : glyph(val_d[4*i +: 4]);
          ssd_d[0]   = ~dp_d[i];
        end
      end
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      digit_q    <= '0;
      cnt_q      <= '0;
      val_q      <= '0;
      dp_q       <= '0;
      blz_q      <= 1'b0;
      ssd        <= 8'hFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      dp_q       <= dp_d;
      blz_q      <= blz_d;
      ssd        <= ssd_d;
      an         <= an_d;
      frame_tick <= frame_d;
    end
  end

endmodule
